// File: rtl/mbgd_pkg.sv
// Shared types, widths and narrowing helper for the MBGD gradient engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state encoding, data/accumulator/shift/counter widths,
// saturation limits, and narrow_data() which applies the MBGD_SAT_EN option
// (saturate when defined, two's-complement wrap when undefined).
package mbgd_pkg;

  localparam int DATA_W  = 8;   // w, b, x, y
  localparam int ERR_W   = 18;  // w*x + b - y without overflow
  localparam int ACCW_W  = 27;  // sum of up to 15 err*x products
  localparam int ACCB_W  = 22;  // sum of up to 15 err terms
  localparam int SHIFT_W = 3;   // learning-rate shift
  localparam int CNT_W   = 4;   // batch size / iteration count / sample index

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  // Narrow an updated parameter back to DATA_W bits.
  function automatic logic signed [DATA_W-1:0] narrow_data(input logic signed [ACCW_W:0] v);
`ifdef MBGD_SAT_EN
    if (v > SAT_MAX) return DATA_W'(SAT_MAX);
    if (v < SAT_MIN) return DATA_W'(SAT_MIN);
    return v[DATA_W-1:0];
`else
    return v[DATA_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/mbgd_mac.sv
// Error computation and batch accumulation for the MBGD gradient engine.
// Latency: sample captured on cap, folded into the accumulators on the next acc cycle.
// Backpressure: none; the engine FSM sequences cap/acc/clr.
// Ports: apb_pclk/resetn clock and async active-low reset; clr zeroes both
// accumulators; cap latches smp_x/smp_y; acc adds err*x into acc_w and err
// into acc_b, where err = w*x + b - y using the current model w, b.
module mbgd_mac
  import mbgd_pkg::*;
(
  input  logic                     apb_pclk,
  input  logic                     resetn,
  input  logic                     clr,
  input  logic                     cap,
  input  logic                     acc,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] smp_x,
  input  logic signed [DATA_W-1:0] smp_y,
  output logic signed [ACCW_W-1:0] acc_w,
  output logic signed [ACCB_W-1:0] acc_b
);

  logic signed [DATA_W-1:0] x_q, y_q;
  logic signed [ERR_W-1:0]  w_e, b_e, x_e, y_e, err;
  logic signed [ACCW_W-1:0] prod;

  // Sign-extend every operand first so the arithmetic is done at ERR_W bits.
  assign w_e  = ERR_W'(w);
  assign b_e  = ERR_W'(b);
  assign x_e  = ERR_W'(x_q);
  assign y_e  = ERR_W'(y_q);
  assign err  = w_e * x_e + b_e - y_e;
  assign prod = ACCW_W'(err) * ACCW_W'(x_q);

  always_ff @(posedge apb_pclk or negedge resetn) begin
    if (!resetn) begin
      x_q   <= '0;
      y_q   <= '0;
      acc_w <= '0;
      acc_b <= '0;
    end else begin
      if (cap) begin
        x_q <= smp_x;
        y_q <= smp_y;
      end
      if (clr) begin
        acc_w <= '0;
        acc_b <= '0;
      end else if (acc) begin
        acc_w <= acc_w + prod;
        acc_b <= acc_b + ACCB_W'(err);
      end
    end
  end

endmodule

// File: rtl/mbgd_grad_engine.sv
// Mini-batch gradient-descent engine for a 1-D linear model y = w*x + b.
// Latency: per sample FETCH (>=1 cycle, waits on smp_valid) + ACCUM (1); UPDATE 1 cycle per batch.
// Backpressure: FETCH holds smp_req/smp_addr until smp_valid; start ignored while busy.
// Ports: apb_pclk, resetn (async active-low); start/batch_size/num_iters/
// lr_shift run request (sampled on start only); smp_req/smp_addr/smp_valid/
// smp_x/smp_y sample fetch handshake; w_out/b_out model; busy, done, state.
// Option: define MBGD_SAT_EN to saturate updated w/b, otherwise they wrap.
module mbgd_grad_engine
  import mbgd_pkg::*;
(
  input  logic                      apb_pclk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [CNT_W-1:0]          batch_size,
  input  logic [CNT_W-1:0]          num_iters,
  input  logic [SHIFT_W-1:0]        lr_shift,
  output logic                      smp_req,
  output logic [CNT_W-1:0]          smp_addr,
  input  logic                      smp_valid,
  input  logic signed [DATA_W-1:0]  smp_x,
  input  logic signed [DATA_W-1:0]  smp_y,
  output logic signed [DATA_W-1:0]  w_out,
  output logic signed [DATA_W-1:0]  b_out,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                state
);

  state_t state_q, state_d;

  logic [CNT_W-1:0]         batch_q, iter_q;
  logic [SHIFT_W-1:0]       shift_q;
  logic signed [DATA_W-1:0] w_q, b_q;
  logic                     done_q;

  logic                     start_run, last_smp, more_iters;
  logic                     mac_clr, mac_cap, mac_acc;
  logic signed [ACCW_W-1:0] acc_w;
  logic signed [ACCB_W-1:0] acc_b;
  logic signed [ACCW_W:0]   w_full;
  logic signed [ACCB_W:0]   b_full;

  // A start with an empty batch or zero iterations completes without a run.
  assign start_run  = start && (batch_size != '0) && (num_iters != '0);
  assign last_smp   = (smp_addr == batch_q - CNT_W'(1));
  assign more_iters = (iter_q != CNT_W'(1));

  mbgd_mac u_mac (
    .apb_pclk (apb_pclk),
    .resetn   (resetn),
    .clr      (mac_clr),
    .cap      (mac_cap),
    .acc      (mac_acc),
    .w        (w_q),
    .b        (b_q),
    .smp_x    (smp_x),
    .smp_y    (smp_y),
    .acc_w    (acc_w),
    .acc_b    (acc_b)
  );

  // >>> on a signed operand is an arithmetic shift, i.e. floor division.
  assign w_full = (ACCW_W+1)'(w_q) - (ACCW_W+1)'(acc_w >>> shift_q);
  assign b_full = (ACCB_W+1)'(b_q) - (ACCB_W+1)'(acc_b >>> shift_q);

  // State register
  always_ff @(posedge apb_pclk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_run) state_d = ST_FETCH;
      ST_FETCH:  if (smp_valid) state_d = ST_ACCUM;
      ST_ACCUM:  state_d = last_smp ? ST_UPDATE : ST_FETCH;
      ST_UPDATE: state_d = more_iters ? ST_FETCH : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    smp_req = 1'b0;
    mac_clr = 1'b0;
    mac_cap = 1'b0;
    mac_acc = 1'b0;
    case (state_q)
      ST_IDLE:   mac_clr = start_run;
      ST_FETCH: begin
        smp_req = 1'b1;
        mac_cap = smp_valid;
      end
      ST_ACCUM:  mac_acc = 1'b1;
      ST_UPDATE: mac_clr = more_iters;
      default:   ;
    endcase
  end

  // Run parameters, sample index, model and completion pulse
  always_ff @(posedge apb_pclk or negedge resetn) begin
    if (!resetn) begin
      smp_addr <= '0;
      batch_q  <= '0;
      iter_q   <= '0;
      shift_q  <= '0;
      w_q      <= '0;
      b_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_run) begin
            smp_addr <= '0;
            batch_q  <= batch_size;
            iter_q   <= num_iters;
            shift_q  <= lr_shift;
          end else if (start) begin
            done_q <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (!last_smp) smp_addr <= smp_addr + CNT_W'(1);
        end
        ST_UPDATE: begin
          w_q    <= narrow_data(w_full);
          b_q    <= narrow_data((ACCW_W+1)'(b_full));
          iter_q <= iter_q - CNT_W'(1);
          if (more_iters) smp_addr <= '0;
          else            done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_out = w_q;
  assign b_out = b_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_mbgd_grad_engine.sv
// Scoreboard bench for mbgd_grad_engine: each run pushes its hand-computed
// final (w, b) into a queue; a monitor pops and compares on every done pulse.
module tb_mbgd_grad_engine;

  logic              apb_pclk = 1'b0;
  logic              resetn   = 1'b0;
  logic              start    = 1'b0;
  logic [3:0]        batch_size = '0;
  logic [3:0]        num_iters  = '0;
  logic [2:0]        lr_shift   = '0;
  logic              smp_req;
  logic [3:0]        smp_addr;
  logic              smp_valid;
  logic signed [7:0] smp_x, smp_y;
  logic signed [7:0] w_out, b_out;
  logic              busy, done;
  logic [1:0]        state;

  mbgd_grad_engine dut (
    .apb_pclk   (apb_pclk),
    .resetn     (resetn),
    .start      (start),
    .batch_size (batch_size),
    .num_iters  (num_iters),
    .lr_shift   (lr_shift),
    .smp_req    (smp_req),
    .smp_addr   (smp_addr),
    .smp_valid  (smp_valid),
    .smp_x      (smp_x),
    .smp_y      (smp_y),
    .w_out      (w_out),
    .b_out      (b_out),
    .busy       (busy),
    .done       (done),
    .state      (state)
  );

  always #5 apb_pclk = ~apb_pclk;

  typedef struct {
    int    w;
    int    b;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;

  logic signed [7:0] mem_x [16];
  logic signed [7:0] mem_y [16];
  int   resp_delay = 0;
  int   stray_cnt  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_run(input int w, input int b, input string name);
    exp_t e;
    e.w = w; e.b = b; e.name = name;
    exp_q.push_back(e);
  endtask

  // Sample memory responder; also injects stray smp_valid pulses on request.
  initial begin
    int wait_cnt   = 0;
    int stray_done = 0;
    smp_valid = 1'b0;
    smp_x     = '0;
    smp_y     = '0;
    forever begin
      @(negedge apb_pclk);
      smp_valid = 1'b0;
      if (stray_cnt != stray_done) begin
        stray_done = stray_cnt;
        smp_valid  = 1'b1;
        smp_x      = 8'sd99;
        smp_y      = -8'sd99;
      end else if (smp_req) begin
        if (wait_cnt >= resp_delay) begin
          smp_valid = 1'b1;
          smp_x     = mem_x[smp_addr];
          smp_y     = mem_y[smp_addr];
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: compares the model on each done pulse against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge apb_pclk);
      #1;
      if (done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_w"}, w_out, e.w);
          chk({e.name, "_b"}, b_out, e.b);
          chk({e.name, "_state"}, state, 0);
        end
      end
    end
  end

  // Start is raised on a falling edge and dropped just after the next rising edge.
  task automatic pulse_start(input int bs, input int ni, input int ls);
    @(negedge apb_pclk);
    batch_size = bs[3:0];
    num_iters  = ni[3:0];
    lr_shift   = ls[2:0];
    start      = 1'b1;
    @(posedge apb_pclk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int cycles);
    cycles = 0;
    while (!done && cycles < 500) begin
      @(posedge apb_pclk);
      #1;
      cycles++;
    end
    if (!done) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_state"},    state, 0);
    chk({name, "_smp_req"},  smp_req, 0);
    chk({name, "_smp_addr"}, smp_addr, 0);
    chk({name, "_w"},        w_out, 0);
    chk({name, "_b"},        b_out, 0);
    chk({name, "_busy"},     busy, 0);
    chk({name, "_done"},     done, 0);
  endtask

  task automatic do_reset();
    @(negedge apb_pclk);
    resetn = 1'b0;
    @(negedge apb_pclk);
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int d0;
    for (int i = 0; i < 16; i++) begin
      mem_x[i] = '0;
      mem_y[i] = '0;
    end

    // Reset values
    repeat (2) @(negedge apb_pclk);
    check_idle_outputs("reset");
    resetn = 1'b1;

    // Basic step: err = -4, so w and b both move to +4.
    // The start on the first edge after release must be accepted.
    mem_x[0] = 8'sd1; mem_y[0] = 8'sd4;
    expect_run(4, 4, "basic");
    pulse_start(1, 1, 0);
    chk("first_start_accepted", state, 1);
    wait_done("basic", cyc);

    // Overflow: err = -127, acc_w = -16129, w = 16129 (wraps to 1).
    do_reset();
    mem_x[0] = 8'sd127; mem_y[0] = 8'sd127;
`ifdef MBGD_SAT_EN
    expect_run(127, 127, "overflow");
`else
    expect_run(1, 127, "overflow");
`endif
    pulse_start(1, 1, 0);
    wait_done("overflow", cyc);

    // Shift and batch: acc_w = -16 >>> 4 = -1; acc_b = -8 >>> 4 rounds down to -1.
    do_reset();
    mem_x[0] = 8'sd2; mem_y[0] = 8'sd4;
    mem_x[1] = 8'sd2; mem_y[1] = 8'sd4;
    expect_run(1, 1, "shift_batch");
    pulse_start(2, 1, 4);
    wait_done("shift_batch", cyc);

    // Stray smp_valid in IDLE does nothing; model (1,1) persists.
    stray_cnt++;
    repeat (3) @(negedge apb_pclk);
    chk("stray_state", state, 0);
    chk("stray_busy", busy, 0);
    chk("stray_w", w_out, 1);
    chk("stray_b", b_out, 1);

    // Slow responder: from w=b=1, err = 1+1-4 = -2 -> w=b=3.
    resp_delay = 5;
    mem_x[0] = 8'sd1; mem_y[0] = 8'sd4;
    expect_run(3, 3, "handshake");
    pulse_start(1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold_req_%0d", i), smp_req, 1);
      chk($sformatf("hold_addr_%0d", i), smp_addr, 0);
      @(posedge apb_pclk);
      #1;
    end
    wait_done("handshake", cyc);
    resp_delay = 0;

    // Two iterations, batch of 2, shift 2, from w=b=3:
    // iter1 acc=(6,6) -> w=b=2; iter2 acc=(4,4) -> w=b=1.
    mem_x[0] = 8'sd1;  mem_y[0] = 8'sd0;
    mem_x[1] = -8'sd1; mem_y[1] = 8'sd0;
    expect_run(1, 1, "multi_iter");
    pulse_start(2, 2, 2);
    wait_done("multi_iter", cyc);

    // Degenerate starts complete on the next cycle without touching the model.
    expect_run(1, 1, "zero_iters");
    pulse_start(3, 0, 0);
    wait_done("zero_iters", cyc);
    chk("zero_iters_latency", cyc, 0);
    chk("zero_iters_busy", busy, 0);
    expect_run(1, 1, "zero_batch");
    pulse_start(0, 2, 0);
    wait_done("zero_batch", cyc);
    chk("zero_batch_latency", cyc, 0);

    // Second start mid-run (with different parameters) is ignored:
    // from w=b=1 with (1,4), err = -2 -> w=b=3, one done only.
    mem_x[0] = 8'sd1; mem_y[0] = 8'sd4;
    d0 = done_seen;
    expect_run(3, 3, "busy_start");
    pulse_start(1, 1, 0);
    pulse_start(2, 3, 1);
    wait_done("busy_start", cyc);
    repeat (40) @(posedge apb_pclk);
    #1;
    chk("busy_start_done_count", done_seen - d0, 1);

    // Abort mid-FETCH: asynchronous reset clears everything at once.
    resp_delay = 20;
    pulse_start(1, 1, 0);
    repeat (2) begin
      @(posedge apb_pclk);
      #1;
    end
    chk("abort_in_fetch", state, 1);
    #2;
    resetn = 1'b0;
    #1;
    check_idle_outputs("abort");
    @(negedge apb_pclk);
    resetn = 1'b1;
    resp_delay = 0;

    // Fresh run after the abort starts from w=b=0.
    expect_run(4, 4, "after_abort");
    pulse_start(1, 1, 0);
    chk("after_abort_accepted", state, 1);
    wait_done("after_abort", cyc);

    repeat (5) @(posedge apb_pclk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
